// File: rtl/pipa_pkg.sv
// rtl/pipa_pkg.sv - shared defaults and helpers for the PIPA moding generator
package pipa_pkg;

  localparam int PIPA_DEF_LEN  = 6;
  localparam int PIPA_DEF_PLUS = 3;
  // Widest phase counter the clamp helper handles; callers zero-extend into it.
  localparam int PIPA_CFG_W    = 8;

  typedef struct packed {
    logic [PIPA_CFG_W-1:0] len;
    logic [PIPA_CFG_W-1:0] plus;
    logic                  err;
  } clamp_t;

  // Frame length floor is 2; plus slots cannot exceed the (clamped) frame length.
  function automatic clamp_t clamp_cfg(input logic [PIPA_CFG_W-1:0] len,
                                       input logic [PIPA_CFG_W-1:0] plus);
    clamp_t r;
    r.err  = 1'b0;
    r.len  = len;
    r.plus = plus;
    if (len < PIPA_CFG_W'(2)) begin
      r.len = PIPA_CFG_W'(2);
      r.err = 1'b1;
    end
    if (plus > r.len) begin
      r.plus = r.len;
      r.err  = 1'b1;
    end
    return r;
  endfunction

  // Saturating +/-1 on a sign-extended accumulator of acc_w significant bits.
  function automatic logic signed [31:0] sat_inc(input logic signed [31:0] acc,
                                                 input logic               dir,
                                                 input int                 acc_w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (acc_w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (dir) return (acc >= hi) ? acc : acc + 32'sd1;
    return (acc <= lo) ? acc : acc - 32'sd1;
  endfunction

endpackage

// File: rtl/pipa_edge_sync.sv
// rtl/pipa_edge_sync.sv - two-flop synchroniser with rising-edge pulse
module pipa_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/pipa_moding_gen.sv
// rtl/pipa_moding_gen.sv - programmable plus/minus PIPA moding generator
module pipa_moding_gen #(
  parameter int NCHAN   = 3,
  parameter int PHASE_W = 3,
  parameter int ACC_W   = 16
) (
  input  logic                     SIM_CLK,
  input  logic                     SIM_RST_n,
  input  logic                     en,
  input  logic                     PIPASW,
  input  logic                     PIPDAT,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [PHASE_W-1:0]       cfg_len,
  input  logic [NCHAN*PHASE_W-1:0] cfg_plus,
  output logic [NCHAN-1:0]         PIPAp,
  output logic [NCHAN-1:0]         PIPAm,
  output logic                     frame_start,
  output logic [NCHAN*ACC_W-1:0]   net_count,
  output logic                     cfg_err
);

  import pipa_pkg::*;

  logic sw_rise;
  logic dat_rise;

  pipa_edge_sync u_sw_sync (
    .clk   (SIM_CLK),
    .rst_n (SIM_RST_n),
    .din   (PIPASW),
    .rise  (sw_rise)
  );

  pipa_edge_sync u_dat_sync (
    .clk   (SIM_CLK),
    .rst_n (SIM_RST_n),
    .din   (PIPDAT),
    .rise  (dat_rise)
  );

  logic [PHASE_W-1:0]       phase;
  logic [PHASE_W-1:0]       len_act;
  logic [PHASE_W-1:0]       len_shd;
  logic [PHASE_W-1:0]       last_phase;
  logic [PHASE_W-1:0]       len_clamped;
  logic [NCHAN*PHASE_W-1:0] plus_act;
  logic [NCHAN*PHASE_W-1:0] plus_shd;
  logic [NCHAN*PHASE_W-1:0] plus_clamped;
  logic [NCHAN-1:0]         ch_err;
  logic [NCHAN-1:0]         plus_sel;
  logic                     shd_valid;
  logic                     wrap;
  logic                     accept;
  logic                     apply;
  logic                     len_err;
  clamp_t                   len_chk;
  logic                     unused_len_chk;

  assign last_phase = len_act - PHASE_W'(1);
  assign wrap       = en & sw_rise & (phase == last_phase);
  assign accept     = cfg_valid & ~shd_valid;
  // Shadow becomes live at a frame boundary, or at once while the generator is idle.
  assign apply      = shd_valid & (wrap | ~en);
  assign cfg_ready  = ~shd_valid;

  assign len_chk        = clamp_cfg(PIPA_CFG_W'(cfg_len), '0);
  assign len_clamped    = len_chk.len[PHASE_W-1:0];
  assign len_err        = len_chk.err;
  assign unused_len_chk = ^len_chk;

  for (genvar i = 0; i < NCHAN; i++) begin : g_clamp
    clamp_t c;
    logic   unused_bits;
    assign c = clamp_cfg(PIPA_CFG_W'(cfg_len), PIPA_CFG_W'(cfg_plus[i*PHASE_W +: PHASE_W]));
    assign plus_clamped[i*PHASE_W +: PHASE_W] = c.plus[PHASE_W-1:0];
    assign ch_err[i]   = c.err;
    assign unused_bits = ^c;
  end

  always_ff @(posedge SIM_CLK or negedge SIM_RST_n) begin
    if (!SIM_RST_n) begin
      phase       <= '0;
      len_act     <= PHASE_W'(PIPA_DEF_LEN);
      plus_act    <= {NCHAN{PHASE_W'(PIPA_DEF_PLUS)}};
      len_shd     <= '0;
      plus_shd    <= '0;
      shd_valid   <= 1'b0;
      cfg_err     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap;
      if (!en) begin
        phase <= '0;
      end else if (sw_rise) begin
        phase <= (phase == last_phase) ? '0 : phase + PHASE_W'(1);
      end
      if (accept) begin
        len_shd   <= len_clamped;
        plus_shd  <= plus_clamped;
        shd_valid <= 1'b1;
        cfg_err   <= cfg_err | len_err | (|ch_err);
      end else if (apply) begin
        shd_valid <= 1'b0;
      end
      if (apply) begin
        len_act  <= len_shd;
        plus_act <= plus_shd;
      end
    end
  end

  for (genvar i = 0; i < NCHAN; i++) begin : g_chan
    logic                    sel;
    logic signed [ACC_W-1:0] cnt;
    logic signed [31:0]      cnt_nxt;
    logic                    unused_nxt;

    // Count direction uses the registered slot select, i.e. the pre-step value.
    assign cnt_nxt    = sat_inc(32'(cnt), sel, ACC_W);
    assign unused_nxt = ^cnt_nxt;

    always_ff @(posedge SIM_CLK or negedge SIM_RST_n) begin
      if (!SIM_RST_n) begin
        sel <= (PIPA_DEF_PLUS > 0);
        cnt <= '0;
      end else begin
        sel <= (phase < plus_act[i*PHASE_W +: PHASE_W]);
        if (en && dat_rise) cnt <= cnt_nxt[ACC_W-1:0];
      end
    end

    assign plus_sel[i]                  = sel;
    assign net_count[i*ACC_W +: ACC_W] = cnt;
  end

  assign PIPAp = {NCHAN{en & PIPDAT}} & plus_sel;
  assign PIPAm = {NCHAN{en & PIPDAT}} & ~plus_sel;

endmodule

// File: tb/tb_pipa_moding_gen.sv
// tb/tb_pipa_moding_gen.sv - directed self-checking bench for pipa_moding_gen
module tb_pipa_moding_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        sw;
  logic        dat;
  logic        cfg_valid;
  logic [2:0]  cfg_len;
  logic [8:0]  cfg_plus;
  logic        cfg_ready;
  logic [2:0]  pipa_p;
  logic [2:0]  pipa_m;
  logic        frame_start;
  logic [47:0] net_count;
  logic        cfg_err;
  logic        s_cfg_ready;
  logic [2:0]  s_pipa_p;
  logic [2:0]  s_pipa_m;
  logic        s_frame_start;
  logic [11:0] s_net_count;
  logic        s_cfg_err;

  int checks = 0;
  int errors = 0;
  int fs_cnt = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_start === 1'b1) fs_cnt++;

  pipa_moding_gen u_dut (
    .SIM_CLK     (clk),
    .SIM_RST_n   (rst_n),
    .en          (en),
    .PIPASW      (sw),
    .PIPDAT      (dat),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_len     (cfg_len),
    .cfg_plus    (cfg_plus),
    .PIPAp       (pipa_p),
    .PIPAm       (pipa_m),
    .frame_start (frame_start),
    .net_count   (net_count),
    .cfg_err     (cfg_err)
  );

  pipa_moding_gen #(.ACC_W(4)) u_sat (
    .SIM_CLK     (clk),
    .SIM_RST_n   (rst_n),
    .en          (en),
    .PIPASW      (sw),
    .PIPDAT      (dat),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (s_cfg_ready),
    .cfg_len     (cfg_len),
    .cfg_plus    (cfg_plus),
    .PIPAp       (s_pipa_p),
    .PIPAm       (s_pipa_m),
    .frame_start (s_frame_start),
    .net_count   (s_net_count),
    .cfg_err     (s_cfg_err)
  );

  function automatic logic [47:0] nc(input int x, input int y, input int z);
    return {16'(z), 16'(y), 16'(x)};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step();
    sw = 1'b1;
    tick(4);
    sw = 1'b0;
    tick(4);
  endtask

  task automatic dat_pulse(output logic [2:0] p, output logic [2:0] m);
    dat = 1'b1;
    #1;
    p = pipa_p;
    m = pipa_m;
    tick(4);
    dat = 1'b0;
    tick(4);
  endtask

  task automatic offer(input logic [2:0] len, input logic [8:0] plus);
    cfg_len   = len;
    cfg_plus  = plus;
    cfg_valid = 1'b1;
    tick(1);
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; sw = 1'b0; dat = 1'b0;
    cfg_valid = 1'b0; cfg_len = '0; cfg_plus = '0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got %b exp 1", cfg_ready); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got %b exp 0", cfg_err); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start got %b exp 0", frame_start); end
    checks++; if (net_count !== 48'h0) begin errors++; $display("FAIL reset_net got %h exp 0", net_count); end
    checks++; if (pipa_p !== 3'b000 || pipa_m !== 3'b000) begin errors++; $display("FAIL reset_pulses got p=%b m=%b exp 000/000", pipa_p, pipa_m); end
  endtask

  task automatic test_default_frame();
    logic [2:0] exp_p [6] = '{3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111};
    logic [2:0] p, m;
    int base;
    en = 1'b1;
    tick(2);
    base = fs_cnt;
    for (int k = 0; k < 6; k++) begin
      step();
      dat_pulse(p, m);
      checks++;
      if (p !== exp_p[k] || m !== ~exp_p[k]) begin
        errors++; $display("FAIL default_step%0d got p=%b m=%b exp p=%b m=%b", k + 1, p, m, exp_p[k], ~exp_p[k]);
      end
    end
    checks++; if (fs_cnt - base !== 1) begin errors++; $display("FAIL default_frame_start got %0d exp 1", fs_cnt - base); end
    checks++; if (net_count !== nc(0, 0, 0)) begin errors++; $display("FAIL default_net got %h exp %h", net_count, nc(0, 0, 0)); end
  endtask

  task automatic test_config();
    logic [2:0] old_p [4] = '{3'b111, 3'b000, 3'b000, 3'b000};
    logic [2:0] new_p [5] = '{3'b111, 3'b101, 3'b101, 3'b101, 3'b001};
    logic [2:0] p, m;
    int base;
    base = fs_cnt;
    step();
    dat_pulse(p, m);
    checks++; if (p !== 3'b111) begin errors++; $display("FAIL cfg_phase1 got p=%b exp 111", p); end
    offer(3'd5, {3'd4, 3'd1, 3'd5});
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg_ready_after_accept got %b exp 0", cfg_ready); end
    for (int k = 0; k < 4; k++) begin
      step();
      dat_pulse(p, m);
      checks++;
      if (p !== old_p[k] || m !== ~old_p[k]) begin
        errors++; $display("FAIL cfg_old_phase%0d got p=%b m=%b exp p=%b", k + 2, p, m, old_p[k]);
      end
    end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg_pending got %b exp 0", cfg_ready); end
    step();
    checks++; if (fs_cnt - base !== 1) begin errors++; $display("FAIL cfg_wrap got %0d exp 1", fs_cnt - base); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg_applied_ready got %b exp 1", cfg_ready); end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step();
      dat_pulse(p, m);
      checks++;
      if (p !== new_p[k] || m !== ~new_p[k]) begin
        errors++; $display("FAIL cfg_new_phase%0d got p=%b m=%b exp p=%b", k, p, m, new_p[k]);
      end
    end
    checks++; if (net_count !== nc(4, -4, 2)) begin errors++; $display("FAIL cfg_net got %h exp %h", net_count, nc(4, -4, 2)); end
    step();
    checks++; if (fs_cnt - base !== 2) begin errors++; $display("FAIL cfg_len5_wrap got %0d exp 2", fs_cnt - base); end
  endtask

  task automatic test_clamp();
    logic [2:0] p, m;
    int base;
    base = fs_cnt;
    offer(3'd1, 9'h1FF);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL clamp_err got %b exp 1", cfg_err); end
    repeat (5) step();
    checks++; if (fs_cnt - base !== 1 || cfg_ready !== 1'b1) begin
      errors++; $display("FAIL clamp_apply got frames=%0d ready=%b exp 1/1", fs_cnt - base, cfg_ready);
    end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) step();
      dat_pulse(p, m);
      checks++;
      if (p !== 3'b111 || m !== 3'b000) begin errors++; $display("FAIL clamp_pulse%0d got p=%b m=%b exp 111/000", k, p, m); end
    end
    checks++; if (fs_cnt - base !== 2) begin errors++; $display("FAIL clamp_len2_wrap got %0d exp 2", fs_cnt - base); end
    checks++; if (net_count !== nc(7, -1, 5)) begin errors++; $display("FAIL clamp_net got %h exp %h", net_count, nc(7, -1, 5)); end
  endtask

  task automatic test_en_off();
    logic [2:0] p, m;
    step();
    offer(3'd4, {3'd3, 3'd2, 3'd1});
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL en_accept got %b exp 0", cfg_ready); end
    en = 1'b0;
    tick(2);
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL en_off_apply got %b exp 1", cfg_ready); end
    step();
    dat_pulse(p, m);
    checks++; if (p !== 3'b000 || m !== 3'b000) begin errors++; $display("FAIL en_off_pulses got p=%b m=%b exp 000/000", p, m); end
    checks++; if (net_count !== nc(7, -1, 5)) begin errors++; $display("FAIL en_off_frozen got %h exp %h", net_count, nc(7, -1, 5)); end
    en = 1'b1;
    tick(2);
    dat_pulse(p, m);
    checks++; if (p !== 3'b111 || m !== 3'b000) begin errors++; $display("FAIL en_on_phase0 got p=%b m=%b exp 111/000", p, m); end
    step();
    dat_pulse(p, m);
    checks++; if (p !== 3'b110 || m !== 3'b001) begin errors++; $display("FAIL en_on_phase1 got p=%b m=%b exp 110/001", p, m); end
    checks++; if (net_count !== nc(7, 1, 7)) begin errors++; $display("FAIL en_on_net got %h exp %h", net_count, nc(7, 1, 7)); end
  endtask

  task automatic test_async_reset();
    logic [2:0] p, m;
    int base;
    en = 1'b0;
    offer(3'd6, {3'd3, 3'd3, 3'd3});
    tick(2);
    en = 1'b1;
    tick(2);
    repeat (4) step();
    offer(3'd3, {3'd1, 3'd1, 3'd1});
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rst_pending got %b exp 0", cfg_ready); end
    rst_n = 1'b0;
    #2;
    checks++; if (cfg_ready !== 1'b1 || cfg_err !== 1'b0 || frame_start !== 1'b0) begin
      errors++; $display("FAIL rst_immediate got ready=%b err=%b fs=%b exp 1/0/0", cfg_ready, cfg_err, frame_start);
    end
    checks++; if (net_count !== 48'h0) begin errors++; $display("FAIL rst_net got %h exp 0", net_count); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(2);
    base = fs_cnt;
    dat_pulse(p, m);
    checks++; if (p !== 3'b111) begin errors++; $display("FAIL rst_phase0 got p=%b exp 111", p); end
    repeat (3) step();
    dat_pulse(p, m);
    checks++; if (p !== 3'b000 || m !== 3'b111) begin errors++; $display("FAIL rst_phase3 got p=%b m=%b exp 000/111", p, m); end
    repeat (2) step();
    checks++; if (fs_cnt - base !== 0) begin errors++; $display("FAIL rst_no_early_wrap got %0d exp 0", fs_cnt - base); end
    step();
    checks++; if (fs_cnt - base !== 1) begin errors++; $display("FAIL rst_len6_wrap got %0d exp 1", fs_cnt - base); end
    checks++; if (net_count !== nc(0, 0, 0)) begin errors++; $display("FAIL rst_net_after got %h exp 0", net_count); end
  endtask

  task automatic test_saturation();
    logic [2:0] p, m;
    en = 1'b0;
    offer(3'd6, {3'd6, 3'd6, 3'd6});
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL sat_no_clamp got %b exp 0", cfg_err); end
    tick(2);
    en = 1'b1;
    tick(2);
    for (int k = 0; k < 10; k++) begin
      dat_pulse(p, m);
      checks++; if (p !== 3'b111) begin errors++; $display("FAIL sat_pulse%0d got p=%b exp 111", k, p); end
    end
    checks++; if (s_net_count !== 12'h777) begin errors++; $display("FAIL sat_hold got %h exp 777", s_net_count); end
    checks++; if (net_count !== nc(10, 10, 10)) begin errors++; $display("FAIL sat_wide got %h exp %h", net_count, nc(10, 10, 10)); end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_default_frame();
    test_config();
    test_clamp();
    test_en_off();
    test_async_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
